fpga_mem_responder: RTL

Memory-side endpoint of the narrow 32-bit multiplexed address/data link driven by the FPGA memory controller. Decodes address, read and write phases, and paces each beat with a one-cycle resp pulse. Services 8-beat (32-byte) line reads and writes against an on-chip word RAM. Sits directly downstream of the controller, in place of off-chip memory in FPGA builds.

---
 rtl/fpga_mem_pkg.sv | 26 ++
 rtl/fpga_mem_sram.sv | 28 ++
 rtl/fpga_mem_responder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fpga_mem_pkg.sv
// Shared types and constants for the FPGA memory responder.
package fpga_mem_pkg;

  localparam int BURST_LEN  = 8;
  localparam int BEAT_W     = 32;
  localparam int LINE_BYTES = 32;
  localparam int LINE_OFF_W = 5;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR_WAIT = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_BEAT_WAIT = 3'd3,
    S_BEAT_ACK  = 3'd4,
    S_DONE_WAIT = 3'd5,
    S_DONE_ACK  = 3'd6,
    S_DRAIN     = 3'd7
  } state_e;

  // Word index of a beat: line base scaled by 8 words plus the beat number.
  // The caller truncates the result to the RAM address width.
  function automatic logic [29:0] word_index(input logic [26:0] base, input logic [2:0] beat);
    return {base, beat};
  endfunction

endpackage

// File: rtl/fpga_mem_sram.sv
// Single-port synchronous word RAM: one-cycle registered read, write-first.
module fpga_mem_sram #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata_q
);

  logic [DW-1:0] mem [2**AW];

  // RAM array and read register; no reset so the tools can map it to block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata_q   <= wdata;
      end else begin
        rdata_q   <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/fpga_mem_responder.sv
// Memory-side endpoint of the multiplexed address/data link: decodes address
// and data phases, paces each phase with a one-cycle resp pulse and services
// 8-beat line reads and writes against an on-chip word RAM.
module fpga_mem_responder #(
  parameter int MEM_ADDR_W = 14,
  parameter int RESP_GAP   = 1,
  parameter int BURST_LEN  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address_data_bus_c_to_m,
  input  logic        address_on_c_to_m,
  input  logic        data_on_c_to_m,
  input  logic        read_en_c_to_m,
  input  logic        write_en_c_to_m,
  output logic [31:0] address_data_bus_m_to_c,
  output logic        resp_m_to_c,
  output logic        busy,
  output logic        proto_err
);
  import fpga_mem_pkg::*;

  localparam int         BASE_W    = MEM_ADDR_W + 2 - LINE_OFF_W;
  localparam logic [3:0] GAP_LAST  = 4'(RESP_GAP - 1);
  localparam logic [3:0] ADDR_LAST = 4'(RESP_GAP - 2);
  localparam logic [2:0] BEAT_LAST = 3'(BURST_LEN - 1);

  typedef logic [MEM_ADDR_W-1:0] ram_addr_t;

  state_e            state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic              is_wr_q, is_wr_d;
  logic [2:0]        beat_q, beat_d;
  logic [3:0]        gap_q, gap_d;
  logic              armed_q, armed_d;
  logic              resp_q, resp_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              rd_vld_q, rd_vld_d;

  logic              own_en_s, opp_en_s, abort_s;
  logic              ram_en_s, ram_we_s;
  ram_addr_t         ram_addr_s;
  logic [31:0]       ram_rdata_s;

  assign own_en_s   = is_wr_q ? write_en_c_to_m : read_en_c_to_m;
  assign opp_en_s   = is_wr_q ? read_en_c_to_m  : write_en_c_to_m;
  assign abort_s    = (!own_en_s) || opp_en_s;
  assign ram_addr_s = ram_addr_t'(word_index(27'(base_q), beat_q));

  // Next-state, RAM control and next-output computation.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    is_wr_d  = is_wr_q;
    beat_d   = beat_q;
    gap_d    = gap_q;
    armed_d  = armed_q;
    err_d    = err_q;
    ram_en_s = 1'b0;
    ram_we_s = 1'b0;

    if ((state_q != S_IDLE) && (state_q != S_DRAIN) && abort_s) begin
      // Enable dropped or the opposite enable appeared: stop quietly.
      state_d = S_DRAIN;
      if (opp_en_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (address_on_c_to_m && read_en_c_to_m && write_en_c_to_m) begin
            err_d = 1'b1;
          end else if (armed_q && address_on_c_to_m && (read_en_c_to_m ^ write_en_c_to_m)) begin
            base_d  = address_data_bus_c_to_m[MEM_ADDR_W+1:LINE_OFF_W];
            is_wr_d = write_en_c_to_m;
            gap_d   = 4'd0;
            beat_d  = 3'd0;
            // With a one-cycle gap the accept cycle itself is the only wait.
            state_d = (RESP_GAP == 1) ? S_ADDR_ACK : S_ADDR_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ADDR_WAIT: begin
          if (gap_q == ADDR_LAST) begin
            state_d = S_ADDR_ACK;
            gap_d   = 4'd0;
          end else begin
            gap_d   = gap_q + 4'd1;
          end
        end
        S_ADDR_ACK: begin
          beat_d  = 3'd0;
          gap_d   = 4'd0;
          state_d = S_BEAT_WAIT;
        end
        S_BEAT_WAIT: begin
          if (gap_q == GAP_LAST) begin
            // Read issued here lands in the RAM output register for the ack.
            ram_en_s = !is_wr_q;
            state_d  = S_BEAT_ACK;
            gap_d    = 4'd0;
          end else begin
            gap_d    = gap_q + 4'd1;
          end
        end
        S_BEAT_ACK: begin
          if (is_wr_q) begin
            if (data_on_c_to_m) begin
              ram_en_s = 1'b1;
              ram_we_s = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            ram_en_s = 1'b0;
          end
          gap_d = 4'd0;
          if (beat_q == BEAT_LAST) begin
            state_d = is_wr_q ? S_DONE_WAIT : S_DRAIN;
          end else begin
            beat_d  = beat_q + 3'd1;
            state_d = S_BEAT_WAIT;
          end
        end
        S_DONE_WAIT: begin
          if (gap_q == GAP_LAST) begin
            state_d = S_DONE_ACK;
            gap_d   = 4'd0;
          end else begin
            gap_d   = gap_q + 4'd1;
          end
        end
        S_DONE_ACK: begin
          state_d = S_DRAIN;
        end
        S_DRAIN: begin
          // Stay disarmed until the controller releases both enables, so a
          // stale address left on the bus is never accepted twice.
          if (!read_en_c_to_m && !write_en_c_to_m) begin
            state_d = S_IDLE;
            armed_d = 1'b1;
          end else begin
            armed_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    resp_d   = (state_d == S_ADDR_ACK) || (state_d == S_BEAT_ACK) || (state_d == S_DONE_ACK);
    rd_vld_d = (state_d == S_BEAT_ACK) && !is_wr_d;
    busy_d   = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= {BASE_W{1'b0}};
      is_wr_q  <= 1'b0;
      beat_q   <= 3'd0;
      gap_q    <= 4'd0;
      armed_q  <= 1'b1;
      resp_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      is_wr_q  <= is_wr_d;
      beat_q   <= beat_d;
      gap_q    <= gap_d;
      armed_q  <= armed_d;
      resp_q   <= resp_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  fpga_mem_sram #(.AW(MEM_ADDR_W), .DW(BEAT_W)) u_sram (
    .clk     (clk),
    .en      (ram_en_s),
    .we      (ram_we_s),
    .addr    (ram_addr_s),
    .wdata   (address_data_bus_c_to_m),
    .rdata_q (ram_rdata_s)
  );

  // Read data comes straight from the RAM output register, qualified by a
  // registered valid so the bus reads zero outside read beats and in reset.
  assign address_data_bus_m_to_c = rd_vld_q ? ram_rdata_s : 32'h0000_0000;
  assign resp_m_to_c             = resp_q;
  assign busy                    = busy_q;
  assign proto_err               = err_q;

endmodule
